pipe_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS pipeline. Drives the StallX/FlushX inputs of every stage register: F/D, D/E, E/M and M/W.
- Resolves four hazard classes: load-use and branch-operand hazards, multi-cycle MDU (mult/div) occupancy, ibus/dbus wait states, and exception/eret redirects.
- Owns a drain FSM that discards an instruction fetch already in flight when a redirect occurs.
- Owns the MDU latency counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_mdu_lat_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / stall-flush controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned DIV_LAT_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 6;

    typedef logic [REG_W-1:0] creg_addr_t;

    typedef struct packed {
        logic stallf;
        logic stalld;
        logic stalle;
        logic stallm;
        logic flushd;
        logic flushe;
        logic flushm;
        logic flushw;
    } pipe_ctrl_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } drain_state_t;

    // True when dst is a real register that the D instruction reads.
    function automatic logic reg_match(input creg_addr_t dst, input creg_addr_t rs,
                                       input creg_addr_t rt, input logic use_rs,
                                       input logic use_rt);
        return (dst != '0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and stall/flush controls back to them.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    creg_addr_t rsD;
    creg_addr_t rtD;
    logic       useRsD;
    logic       useRtD;
    logic       branchD;
    logic       regwriteE;
    logic       memtoregE;
    creg_addr_t writeregE;
    logic       memtoregM;
    creg_addr_t writeregM;
    logic       mdu_startE;
    logic       is_divE;
    logic       iwait;
    logic       idata_ok;
    logic       dwait;
    logic       excM;

    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushM, FlushW;
    logic fetch_drop;
    logic mdu_busy;
    logic mdu_abort;

    modport master (
        output rsD, rtD, useRsD, useRtD, branchD, regwriteE, memtoregE, writeregE,
               memtoregM, writeregM, mdu_startE, is_divE, iwait, idata_ok, dwait, excM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               fetch_drop, mdu_busy, mdu_abort
    );

    modport slave (
        input  rsD, rtD, useRsD, useRtD, branchD, regwriteE, memtoregE, writeregE,
               memtoregM, writeregM, mdu_startE, is_divE, iwait, idata_ok, dwait, excM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               fetch_drop, mdu_busy, mdu_abort
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_lat_counter.sv
// MDU occupancy counter: loads the op latency on issue, counts down, cleared on redirect.
module pipe_hazard_ctrl_mdu_lat_counter #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic is_div,
    input  logic abort,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with fetch-drain FSM and MDU counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    pipe_hazard_ctrl_if.slave  hif
);

    drain_state_t state, state_nxt;
    pipe_ctrl_t   ctrl;
    logic         loaduse, brhaz, mdu_busy, mdu_start, mdu_abort, fetch_drop;

    assign loaduse = hif.memtoregE &
                     reg_match(hif.writeregE, hif.rsD, hif.rtD, hif.useRsD, hif.useRtD);
    assign brhaz   = hif.branchD &
                     ((hif.regwriteE &
                       reg_match(hif.writeregE, hif.rsD, hif.rtD, hif.useRsD, hif.useRtD)) |
                      (hif.memtoregM &
                       reg_match(hif.writeregM, hif.rsD, hif.rtD, hif.useRsD, hif.useRtD)));

    assign mdu_start  = hif.mdu_startE & ~mdu_busy & ~hif.excM & ~hif.dwait;
    assign fetch_drop = (state == S_DRAIN);

    pipe_hazard_ctrl_mdu_lat_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_cnt (
        .clk    (clk),
        .resetn (resetn),
        .start  (mdu_start),
        .is_div (hif.is_divE),
        .abort  (hif.excM),
        .busy   (mdu_busy)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next drain state and prioritised stall/flush decode.
    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        mdu_abort = 1'b0;

        unique case (state)
            S_IDLE:  if (hif.excM && hif.iwait) state_nxt = S_DRAIN;
            S_DRAIN: if (hif.idata_ok)          state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (hif.excM) begin
            ctrl.flushd = 1'b1;
            ctrl.flushe = 1'b1;
            ctrl.flushm = 1'b1;
            ctrl.flushw = 1'b1;
            mdu_abort   = mdu_busy;
        end else if (hif.dwait) begin
            ctrl.stallf = 1'b1;
            ctrl.stalld = 1'b1;
            ctrl.stalle = 1'b1;
            ctrl.stallm = 1'b1;
            ctrl.flushw = 1'b1;
        end else if (mdu_busy) begin
            ctrl.stallf = 1'b1;
            ctrl.stalld = 1'b1;
            ctrl.stalle = 1'b1;
            ctrl.flushm = 1'b1;
        end else if (loaduse || brhaz) begin
            ctrl.stallf = 1'b1;
            ctrl.stalld = 1'b1;
            ctrl.flushe = 1'b1;
        end else if (hif.iwait || fetch_drop) begin
            ctrl.stallf = 1'b1;
            ctrl.flushd = 1'b1;
        end

        // A held stage register must keep its contents.
        ctrl.flushd = ctrl.flushd & ~ctrl.stalld;
        ctrl.flushe = ctrl.flushe & ~ctrl.stalle;
        ctrl.flushm = ctrl.flushm & ~ctrl.stallm;
    end

    assign hif.StallF     = ctrl.stallf;
    assign hif.StallD     = ctrl.stalld;
    assign hif.StallE     = ctrl.stalle;
    assign hif.StallM     = ctrl.stallm;
    assign hif.FlushD     = ctrl.flushd;
    assign hif.FlushE     = ctrl.flushe;
    assign hif.FlushM     = ctrl.flushm;
    assign hif.FlushW     = ctrl.flushw;
    assign hif.fetch_drop = fetch_drop;
    assign hif.mdu_busy   = mdu_busy;
    assign hif.mdu_abort  = mdu_abort;

endmodule
